// File: rtl/nn_rom_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nn_rom_pkg : shared widths and FSM encoding for the weight ROM arbiter |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
package nn_rom_pkg;

  localparam int c_DEF_ADDR_WIDTH = 16;
  localparam int c_DEF_DATA_WIDTH = 16;
  localparam int c_DEF_LEN_WIDTH  = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage : nn_rom_pkg
`default_nettype wire

// File: rtl/weight_rom_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | weight_rom_arbiter_if : requester/ROM bus seen by the weight arbiter  |
// | Revision             : 1.0                                           |
// +----------------------------------------------------------------------+
interface weight_rom_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 10
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] base_addr;
  logic [NUM_REQ*LEN_WIDTH-1:0]  burst_len;
  logic [NUM_REQ-1:0]            grant;
  logic                          busy;
  logic [ADDR_WIDTH-1:0]         rom_addr;
  logic [DATA_WIDTH-1:0]         rom_q;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic [NUM_REQ-1:0]            rsp_last;

  // Engines plus the ROM read port form the master side.
  modport master (
    output req, base_addr, burst_len, rom_q,
    input  grant, busy, rom_addr, rsp_valid, rsp_data, rsp_last
  );

  modport slave (
    input  req, base_addr, burst_len, rom_q,
    output grant, busy, rom_addr, rsp_valid, rsp_data, rsp_last
  );

endinterface : weight_rom_arbiter_if
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter : round-robin one-hot grant, pointer advances on accept    |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] grant_o
);

  localparam int                 c_PTR_W = $clog2(NUM_REQ);
  localparam logic [c_PTR_W:0]   c_NUM   = (c_PTR_W+1)'(NUM_REQ);
  localparam logic [c_PTR_W:0]   c_LAST  = (c_PTR_W+1)'(NUM_REQ - 1);

  logic [c_PTR_W-1:0] ptr_q;
  logic [c_PTR_W-1:0] ptr_d;
  logic [c_PTR_W:0]   idx;

  // Scan farthest-to-nearest so the requester closest to the pointer wins.
  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    idx     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_q} + (c_PTR_W+1)'(k);
      if (idx >= c_NUM) begin
        idx = idx - c_NUM;
      end
      if (req_i[idx[c_PTR_W-1:0]]) begin
        grant_o                    = '0;
        grant_o[idx[c_PTR_W-1:0]]  = en_i;
        ptr_d = (idx == c_LAST) ? '0 : idx[c_PTR_W-1:0] + c_PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (en_i) begin
      ptr_q <= ptr_d;
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/weight_rom_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | weight_rom_arbiter : shares one 1-cycle ROM among layer engines,      |
// |                      round-robin bursts with valid/last to the owner. |
// | Revision           : 1.0                                             |
// +----------------------------------------------------------------------+
module weight_rom_arbiter
  import nn_rom_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = c_DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = c_DEF_LEN_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  weight_rom_arbiter_if.slave  bus_if
);

  state_e                state_q;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    owner_q;
  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic [NUM_REQ-1:0]    rsp_last_q;
  logic [ADDR_WIDTH-1:0] rom_addr_q;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic                  busy_q;
  logic                  arb_en;
  logic [ADDR_WIDTH-1:0] sel_base;
  logic [LEN_WIDTH-1:0]  sel_len;

  // Gating with reset_n keeps grant quiet while reset is asserted.
  assign arb_en = (state_q == IDLE) && reset_n;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk     (clk),
    .reset_n (reset_n),
    .req_i   (bus_if.req),
    .en_i    (arb_en),
    .grant_o (grant)
  );

  always_comb begin
    sel_base = '0;
    sel_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_base = sel_base | ({ADDR_WIDTH{grant[i]}} & bus_if.base_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
      sel_len  = sel_len  | ({LEN_WIDTH{grant[i]}}  & bus_if.burst_len[i*LEN_WIDTH +: LEN_WIDTH]);
    end
  end

  // Every BURST cycle issues rom_addr_q; its word returns one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rsp_valid_q <= '0;
      rsp_last_q  <= '0;
      rom_addr_q  <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rsp_valid_q <= '0;
          rsp_last_q  <= '0;
          if (|grant) begin
            owner_q     <= grant;
            rom_addr_q  <= sel_base;
            remaining_q <= sel_len;
            busy_q      <= 1'b1;
            state_q     <= BURST;
          end
        end
        BURST: begin
          rsp_valid_q <= owner_q;
          if (remaining_q == '0) begin
            rsp_last_q <= owner_q;
            state_q    <= DRAIN;
          end else begin
            rsp_last_q  <= '0;
            rom_addr_q  <= rom_addr_q + ADDR_WIDTH'(1);
            remaining_q <= remaining_q - LEN_WIDTH'(1);
          end
        end
        DRAIN: begin
          rsp_valid_q <= '0;
          rsp_last_q  <= '0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus_if.grant     = grant;
  assign bus_if.busy      = busy_q;
  assign bus_if.rom_addr  = rom_addr_q;
  assign bus_if.rsp_valid = rsp_valid_q;
  assign bus_if.rsp_last  = rsp_last_q;
  assign bus_if.rsp_data  = bus_if.rom_q;

endmodule : weight_rom_arbiter
`default_nettype wire
